hazard_ctrl: RTL

Pipeline hazard controller that drives the stall/bubble controls for the fetch→decode register and `decode_reg` (decode→execute). It detects load-use hazards between decode and execute, flushes both registers on a branch mispredict resolved in execute, and sequences multi-cycle execute ops (mul/div) with an internal countdown FSM. It also keeps free-running hazard performance counters. It sits in the pipeline top beside the stage registers, and its outputs connect directly to their `*_stall_i`/`*_bubble_i` inputs.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stage registers and hazard_ctrl.
// Carries decode/execute operand info in, and stall/bubble/perf results out.
// No handshake of its own: outputs are consumed directly by the stage registers.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs1_i;
    logic [4:0]       D_rs2_i;
    logic             D_use_rs1_i;
    logic             D_use_rs2_i;
    logic             D_multi_i;
    logic             DD_need_dstE_i;
    logic [4:0]       DD_dstE_i;
    logic             DD_is_load_i;
    logic             E_mispredict_i;
    logic             F_stall_o;
    logic             F_bubble_o;
    logic             D_stall_o;
    logic             D_bubble_o;
    logic             E_busy_o;
    logic             E_done_o;
    logic [CNT_W-1:0] lu_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] busy_cnt_o;

    // Pipeline side: supplies stage info, receives controls.
    modport master (
        output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, D_multi_i,
               DD_need_dstE_i, DD_dstE_i, DD_is_load_i, E_mispredict_i,
        input  F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_busy_o, E_done_o,
               lu_cnt_o, flush_cnt_o, busy_cnt_o
    );

    // Controller side.
    modport slave (
        input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, D_multi_i,
               DD_need_dstE_i, DD_dstE_i, DD_is_load_i, E_mispredict_i,
        output F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_busy_o, E_done_o,
               lu_cnt_o, flush_cnt_o, busy_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, mispredict flush, multi-cycle op sequencing.
// Latency: stall/bubble controls are combinational (zero cycles); E_busy/E_done are registered.
// Backpressure: holds fetch/decode for the whole multi-cycle op; load-use costs one bubble.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic          clk_i,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAUNCH_CNT = 4'(MUL_LAT - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             e_busy_q;
    logic             e_done_q;
    logic             lu;
    logic             f_stall;
    logic             f_bubble;
    logic             d_stall;
    logic             d_bubble;
    logic             launch;
    logic             lu_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] busy_cnt;

    // Load in execute feeding a source of the decode instruction; x0 never hazards.
    assign lu = hz.DD_is_load_i && hz.DD_need_dstE_i && (hz.DD_dstE_i != 5'd0) &&
                ((hz.D_use_rs1_i && (hz.D_rs1_i == hz.DD_dstE_i)) ||
                 (hz.D_use_rs2_i && (hz.D_rs2_i == hz.DD_dstE_i)));

    assign flush_evt = (state == IDLE) && hz.E_mispredict_i;
    assign lu_evt    = (state == IDLE) && !hz.E_mispredict_i && lu;

    // Priority decode of stage controls; reset forces both registers to nop.
    always_comb begin
        f_stall  = 1'b0;
        f_bubble = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        if (!rst_n) begin
            f_bubble = 1'b1;
            d_bubble = 1'b1;
        end else if (state == BUSY) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
        end else if (hz.E_mispredict_i) begin
            f_bubble = 1'b1;
            d_bubble = 1'b1;
        end else if (lu) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
        end
    end

    // A multi-cycle op only launches when decode is actually advancing into execute.
    assign launch = (state == IDLE) && hz.D_multi_i && !d_stall && !d_bubble;

    // Countdown FSM; busy/done flags are registered from the next count value.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            e_busy_q <= 1'b0;
            e_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= BUSY;
                        cnt      <= LAUNCH_CNT;
                        e_busy_q <= (LAUNCH_CNT > 4'd1);
                        e_done_q <= (LAUNCH_CNT == 4'd1);
                    end
                end
                BUSY: begin
                    cnt      <= cnt - 4'd1;
                    e_busy_q <= (cnt > 4'd2);
                    e_done_q <= (cnt == 4'd2);
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= 4'd0;
                    e_busy_q <= 1'b0;
                    e_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt    <= '0;
            flush_cnt <= '0;
            busy_cnt  <= '0;
        end else begin
            if (lu_evt)         lu_cnt    <= lu_cnt + CNT_W'(1);
            if (flush_evt)      flush_cnt <= flush_cnt + CNT_W'(1);
            if (state == BUSY)  busy_cnt  <= busy_cnt + CNT_W'(1);
        end
    end

    assign hz.F_stall_o   = f_stall;
    assign hz.F_bubble_o  = f_bubble;
    assign hz.D_stall_o   = d_stall;
    assign hz.D_bubble_o  = d_bubble;
    assign hz.E_busy_o    = e_busy_q;
    assign hz.E_done_o    = e_done_q;
    assign hz.lu_cnt_o    = lu_cnt;
    assign hz.flush_cnt_o = flush_cnt;
    assign hz.busy_cnt_o  = busy_cnt;
endmodule
